// File: rtl/loc_pkg.sv
// Shared location, direction and FSM encodings for the maze BFS controller.
// A location is {row, col}; the helpers split it back into its fields.
package loc_pkg;

    localparam int ROW_W = 4;
    localparam int COL_W = 4;
    localparam int LOC_W = ROW_W + COL_W;
    localparam int MAP_SIZE = 1 << LOC_W;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // NB0..NB3 occupy 4..7 so the low two state bits are the direction code
    localparam logic [3:0] ST_IDLE = 4'd0;
    localparam logic [3:0] ST_SEED = 4'd1;
    localparam logic [3:0] ST_POP  = 4'd2;
    localparam logic [3:0] ST_LOAD = 4'd3;
    localparam logic [3:0] ST_NB0  = 4'd4;
    localparam logic [3:0] ST_NB1  = 4'd5;
    localparam logic [3:0] ST_NB2  = 4'd6;
    localparam logic [3:0] ST_NB3  = 4'd7;
    localparam logic [3:0] ST_DONE = 4'd8;

    function automatic logic [ROW_W-1:0] loc_row(input logic [LOC_W-1:0] loc);
        return loc[LOC_W-1:COL_W];
    endfunction

    function automatic logic [COL_W-1:0] loc_col(input logic [LOC_W-1:0] loc);
        return loc[COL_W-1:0];
    endfunction

endpackage

// File: rtl/neighbour_calc.sv
// Combinational neighbour of a location in one of four directions.
// inBounds drops when the step would leave the grid; there is no wrap-around.
module neighbour_calc
    import loc_pkg::*;
(
    input  logic [LOC_W-1:0] loc,
    input  logic [1:0]       dir,
    output logic [LOC_W-1:0] nbLoc,
    output logic             inBounds
);

    logic [ROW_W-1:0] row, nbRow;
    logic [COL_W-1:0] col, nbCol;

    assign row = loc_row(loc);
    assign col = loc_col(loc);

    always_comb begin
        nbRow    = row;
        nbCol    = col;
        inBounds = 1'b1;
        case (dir)
            DIR_UP: begin
                inBounds = (row != '0);
                nbRow    = row - 1'b1;
            end
            DIR_RIGHT: begin
                inBounds = (col != '1);
                nbCol    = col + 1'b1;
            end
            DIR_DOWN: begin
                inBounds = (row != '1);
                nbRow    = row + 1'b1;
            end
            default: begin
                inBounds = (col != '0);
                nbCol    = col - 1'b1;
            end
        endcase
    end

    assign nbLoc = {nbRow, nbCol};

endmodule

// File: rtl/bfs_expander.sv
// Breadth-first maze search controller: seeds, pops and refills an external
// location queue, checking each neighbour against the wall map and a visited bitmap.
module bfs_expander
    import loc_pkg::*;
#(
    parameter int Q_DEPTH = 63
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LOC_W-1:0] srcLoc,
    input  logic [LOC_W-1:0] dstLoc,
    input  logic [LOC_W-1:0] qLoc,
    input  logic             qNotEmpty,
    output logic [LOC_W-1:0] locIn,
    output logic             enqueue,
    output logic             dequeue,
    output logic [LOC_W-1:0] mazeAddr,
    input  logic             mazeWall,
    output logic             done,
    output logic             found,
    output logic             overflow,
    output logic [3:0]       dbgState
);

    localparam int CNT_W = $clog2(Q_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(Q_DEPTH);

    logic [3:0]          state;
    logic [LOC_W-1:0]    cur;
    logic [MAP_SIZE-1:0] visited;
    logic [CNT_W-1:0]    enqCnt;

    logic             isNb;
    logic [LOC_W-1:0] nbLoc;
    logic             inBounds;
    logic             nbOpen;
    logic             qFull;

    neighbour_calc u_nb (
        .loc     (cur),
        .dir     (state[1:0]),
        .nbLoc   (nbLoc),
        .inBounds(inBounds)
    );

    assign isNb     = (state >= ST_NB0) && (state <= ST_NB3);
    assign nbOpen   = isNb && inBounds && !mazeWall && !visited[nbLoc];
    assign qFull    = (enqCnt == CNT_MAX);
    assign dbgState = state;

    // Queue strobes are single-cycle writes/reads with no back-pressure:
    // enqueue pushes locIn on the edge, dequeue makes qLoc valid next cycle,
    // and the two are never high together.
    always_comb begin
        enqueue  = 1'b0;
        dequeue  = 1'b0;
        locIn    = '0;
        mazeAddr = isNb ? nbLoc : '0;
        case (state)
            ST_SEED: begin
                enqueue = 1'b1;
                locIn   = srcLoc;
            end
            ST_POP: dequeue = qNotEmpty;
            ST_NB0, ST_NB1, ST_NB2, ST_NB3: begin
                if (nbOpen && !qFull) begin
                    enqueue = 1'b1;
                    locIn   = nbLoc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cur      <= '0;
            visited  <= '0;
            enqCnt   <= '0;
            done     <= 1'b0;
            found    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        visited  <= '0;
                        enqCnt   <= '0;
                        done     <= 1'b0;
                        found    <= 1'b0;
                        overflow <= 1'b0;
                        state    <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    visited[srcLoc] <= 1'b1;
                    enqCnt          <= CNT_W'(1);
                    state           <= ST_POP;
                end
                ST_POP: begin
                    if (!qNotEmpty) begin
                        done  <= 1'b1;
                        found <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    cur <= qLoc;
                    if (qLoc == dstLoc) begin
                        done  <= 1'b1;
                        found <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_NB0;
                    end
                end
                ST_NB0, ST_NB1, ST_NB2, ST_NB3: begin
                    if (nbOpen && qFull) begin
                        // a needed enqueue with no room left ends the search
                        overflow <= 1'b1;
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        if (nbOpen) begin
                            visited[nbLoc] <= 1'b1;
                            enqCnt         <= enqCnt + 1'b1;
                        end
                        state <= (state == ST_NB3) ? ST_POP : state + 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bfs_expander.sv
// Directed bench for bfs_expander with a behavioural location queue and wall map.
module tb_bfs_expander;
    import loc_pkg::*;

    localparam int MAXC = 5000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LOC_W-1:0] srcLoc, dstLoc, qLoc, locIn, mazeAddr;
    logic             qNotEmpty, enqueue, dequeue, mazeWall;
    logic             done, found, overflow;
    logic [3:0]       dbgState;
    logic [MAP_SIZE-1:0] walls;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bfs_expander dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .srcLoc   (srcLoc),
        .dstLoc   (dstLoc),
        .qLoc     (qLoc),
        .qNotEmpty(qNotEmpty),
        .locIn    (locIn),
        .enqueue  (enqueue),
        .dequeue  (dequeue),
        .mazeAddr (mazeAddr),
        .mazeWall (mazeWall),
        .done     (done),
        .found    (found),
        .overflow (overflow),
        .dbgState (dbgState)
    );

    assign mazeWall = walls[mazeAddr];

    // Behavioural queue: registered read data, shares rst with the DUT
    logic [LOC_W-1:0] fifo[$];
    logic [LOC_W-1:0] enqLog[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo.delete();
            enqLog.delete();
            qLoc      <= '0;
            qNotEmpty <= 1'b0;
        end else begin
            if (enqueue) begin
                fifo.push_back(locIn);
                enqLog.push_back(locIn);
            end
            if (dequeue && fifo.size() > 0) qLoc <= fifo.pop_front();
            qNotEmpty <= (fifo.size() != 0);
        end
    end

    typedef struct {
        string            name;
        logic [LOC_W-1:0] src;
        logic [LOC_W-1:0] dst;
        logic [LOC_W-1:0] w[3];
        int               nw;
        int               expCyc;
        logic             expFound;
        logic             expOvf;
        int               expEnq;
        logic [LOC_W-1:0] expQ[3];
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic launch(input logic [LOC_W-1:0] s, input logic [LOC_W-1:0] d);
        srcLoc = s;
        dstLoc = d;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(output int cyc);
        cyc = 1;
        while (!done && cyc < MAXC) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic checkSeq(input string name, input logic [LOC_W-1:0] exp[3], input int n);
        for (int i = 0; i < n && i < 3; i++) begin
            if (enqLog.size() > i) check($sformatf("%s_enq%0d", name, i), 32'(enqLog[i]), 32'(exp[i]));
            else check($sformatf("%s_enq%0d_missing", name, i), 32'(enqLog.size()), 32'(i + 1));
        end
    endtask

    initial begin
        int cyc;
        rst    = 1'b1;
        start  = 1'b0;
        srcLoc = '0;
        dstLoc = '0;
        walls  = '0;

        vecs[0] = '{"same_src_dst", 8'h00, 8'h00, '{8'h00, 8'h00, 8'h00}, 0, 4,  1'b1, 1'b0, 1, '{8'h00, 8'h00, 8'h00}};
        vecs[1] = '{"adjacent_dst", 8'h00, 8'h01, '{8'h00, 8'h00, 8'h00}, 0, 10, 1'b1, 1'b0, 3, '{8'h00, 8'h01, 8'h10}};
        vecs[2] = '{"boxed_src",    8'h00, 8'h55, '{8'h01, 8'h10, 8'h00}, 2, 9,  1'b0, 1'b0, 1, '{8'h00, 8'h00, 8'h00}};
        vecs[3] = '{"corner_ff",    8'hFF, 8'h00, '{8'hDF, 8'hEE, 8'hFD}, 3, 21, 1'b0, 1'b0, 3, '{8'hFF, 8'hEF, 8'hFE}};

        #2;
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_enqueue", 32'(enqueue), 32'd0);
        check("rst_dequeue", 32'(dequeue), 32'd0);
        check("rst_state", 32'(dbgState), 32'(ST_IDLE));
        @(posedge clk);
        #1 rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            resetPulse();
            walls = '0;
            for (int k = 0; k < vecs[v].nw; k++) walls[vecs[v].w[k]] = 1'b1;
            launch(vecs[v].src, vecs[v].dst);
            waitDone(cyc);
            check({vecs[v].name, "_done_cycle"}, 32'(cyc), 32'(vecs[v].expCyc));
            check({vecs[v].name, "_done"}, 32'(done), 32'd1);
            check({vecs[v].name, "_found"}, 32'(found), 32'(vecs[v].expFound));
            check({vecs[v].name, "_overflow"}, 32'(overflow), 32'(vecs[v].expOvf));
            check({vecs[v].name, "_enq_count"}, 32'(enqLog.size()), 32'(vecs[v].expEnq));
            checkSeq(vecs[v].name, vecs[v].expQ, vecs[v].expEnq);
            @(posedge clk);
            #1 check({vecs[v].name, "_done_held"}, 32'(done), 32'd1);
        end

        // Capacity exhausted long before the far corner is reached
        resetPulse();
        walls = '0;
        launch(8'h00, 8'hFF);
        waitDone(cyc);
        check("ovf_done", 32'(done), 32'd1);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_found", 32'(found), 32'd0);
        check("ovf_enq_count", 32'(enqLog.size()), 32'd63);
        checkSeq("ovf", '{8'h00, 8'h01, 8'h10}, 3);

        // Asynchronous abort in NB2, then a clean re-run
        resetPulse();
        walls = '0;
        launch(8'h00, 8'h01);
        for (int i = 1; i < 6; i++) begin
            @(posedge clk);
            #1;
        end
        check("nb2_state", 32'(dbgState), 32'(ST_NB2));
        check("nb2_enqueue", 32'(enqueue), 32'd1);
        check("nb2_locIn", 32'(locIn), 32'h10);
        rst = 1'b1;
        #1;
        check("abort_enqueue", 32'(enqueue), 32'd0);
        check("abort_locIn", 32'(locIn), 32'd0);
        check("abort_mazeAddr", 32'(mazeAddr), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_found", 32'(found), 32'd0);
        check("abort_state", 32'(dbgState), 32'(ST_IDLE));
        @(posedge clk);
        #1 rst = 1'b0;
        launch(8'h00, 8'h01);
        waitDone(cyc);
        check("rerun_done_cycle", 32'(cyc), 32'd10);
        check("rerun_found", 32'(found), 32'd1);
        check("rerun_enq_count", 32'(enqLog.size()), 32'd3);
        checkSeq("rerun", '{8'h00, 8'h01, 8'h10}, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
